// File: rtl/pipe_stall_ctrl.sv
// Fetch-side pipeline controller: PC, IF/ID, ID/EX and EX/MEM instruction registers with stall,
// branch flush and a stall-timeout halt. Optional perf counters under macro STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_en,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] id_ex_instr,
  output logic [31:0] ex_mem_instr,
  output logic        stall_err
`ifdef STALL_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  // stall_len must reach MAX_STALL+1 (the halting stall cycle)
  localparam int SL_W = ($clog2(MAX_STALL + 2) < 2) ? 2 : $clog2(MAX_STALL + 2);
  localparam logic [SL_W-1:0] MAX_SL = SL_W'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;
  logic [31:0]     if_id_pc_q, if_id_pc_d;
  logic [31:0]     id_ex_instr_q, id_ex_instr_d;
  logic [31:0]     ex_mem_instr_q, ex_mem_instr_d;
  logic [SL_W-1:0] stall_len_q, stall_len_d;
`ifdef STALL_PERF_EN
  logic [15:0]     stall_cycles_q, flush_count_q;
  logic            stall_cyc, flush_cyc;
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_pc_d     = if_id_pc_q;
    id_ex_instr_d  = id_ex_instr_q;
    ex_mem_instr_d = ex_mem_instr_q;
    stall_len_d    = stall_len_q;
`ifdef STALL_PERF_EN
    stall_cyc      = 1'b0;
    flush_cyc      = 1'b0;
`endif
    if (pipe_en && state_q != HALT) begin
      ex_mem_instr_d = id_ex_instr_q;
      if (id_stall) begin
        id_ex_instr_d = NOP;
        stall_len_d   = stall_len_q + SL_W'(1);
        state_d       = (stall_len_q == MAX_SL) ? HALT : STALL;
`ifdef STALL_PERF_EN
        stall_cyc     = 1'b1;
`endif
      end else begin
        stall_len_d   = '0;
        state_d       = RUN;
        id_ex_instr_d = if_id_instr_q;
        if_id_pc_d    = pc_q;
        if (branch_taken) begin
          pc_d          = branch_target;
          if_id_instr_d = NOP;
`ifdef STALL_PERF_EN
          flush_cyc     = 1'b1;
`endif
        end else begin
          pc_d          = pc_q + 32'd4;
          if_id_instr_d = imem_instr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      if_id_instr_q  <= NOP;
      if_id_pc_q     <= '0;
      id_ex_instr_q  <= NOP;
      ex_mem_instr_q <= NOP;
      stall_len_q    <= '0;
`ifdef STALL_PERF_EN
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_pc_q     <= if_id_pc_d;
      id_ex_instr_q  <= id_ex_instr_d;
      ex_mem_instr_q <= ex_mem_instr_d;
      stall_len_q    <= stall_len_d;
`ifdef STALL_PERF_EN
      if (stall_cyc && stall_cycles_q != 16'hFFFF) stall_cycles_q <= stall_cycles_q + 16'd1;
      if (flush_cyc && flush_count_q != 16'hFFFF)  flush_count_q  <= flush_count_q + 16'd1;
`endif
    end
  end

  assign pc           = pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc     = if_id_pc_q;
  assign id_ex_instr  = id_ex_instr_q;
  assign ex_mem_instr = ex_mem_instr_q;
  assign stall_err    = (state_q == HALT);
`ifdef STALL_PERF_EN
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the pipeline.
module tb_pipe_stall_ctrl;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          MAX_STALL = 2;

  logic        clk = 1'b0;
  logic        rst_n, pipe_en, id_stall, branch_taken;
  logic [31:0] branch_target, imem_instr;
  logic [31:0] pc, if_id_instr, if_id_pc, id_ex_instr, ex_mem_instr;
  logic        stall_err;
`ifdef STALL_PERF_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int errors = 0;
  int checks = 0;

  pipe_stall_ctrl #(.RESET_PC(32'h0000_0000), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .id_stall(id_stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem_instr(imem_instr),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .id_ex_instr(id_ex_instr),
    .ex_mem_instr(ex_mem_instr), .stall_err(stall_err)
`ifdef STALL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // model: pipeline contents plus length of the current run of consecutive stalls
  logic [31:0] m_pc, m_if_instr, m_if_pc, m_id_ex, m_ex_mem;
  int          m_run;
  bit          m_halt;
  int          m_stalls, m_flushes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_if_instr = NOP; m_if_pc = 32'h0; m_id_ex = NOP; m_ex_mem = NOP;
    m_run = 0; m_halt = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step(input bit en, input bit st, input bit br,
                            input logic [31:0] tgt, input logic [31:0] instr);
    if (!en || m_halt) return;
    m_ex_mem = m_id_ex;
    if (st) begin
      m_id_ex = NOP;
      m_run++;
      if (m_stalls < 65535) m_stalls++;
      if (m_run > MAX_STALL) m_halt = 1;
    end else begin
      m_run      = 0;
      m_id_ex    = m_if_instr;
      m_if_pc    = m_pc;
      m_if_instr = br ? NOP : instr;
      m_pc       = br ? tgt : m_pc + 32'd4;
      if (br && m_flushes < 65535) m_flushes++;
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("if_id_instr", if_id_instr, m_if_instr);
    check("if_id_pc", if_id_pc, m_if_pc);
    check("id_ex_instr", id_ex_instr, m_id_ex);
    check("ex_mem_instr", ex_mem_instr, m_ex_mem);
    check("stall_err", {31'b0, stall_err}, {31'b0, m_halt});
`ifdef STALL_PERF_EN
    check("stall_cycles", {16'b0, stall_cycles}, m_stalls);
    check("flush_count", {16'b0, flush_count}, m_flushes);
`endif
  endtask

  task automatic step(input bit rn, input bit en, input bit st, input bit br,
                      input logic [31:0] tgt, input logic [31:0] instr);
    rst_n = rn; pipe_en = en; id_stall = st; branch_taken = br;
    branch_target = tgt; imem_instr = instr;
    if (!rn) model_reset();
    else model_step(en, st, br, tgt, instr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n = 1'b0; pipe_en = 1'b0; id_stall = 1'b1; branch_taken = 1'b1;
    branch_target = 32'hDEAD_BEEF; imem_instr = 32'hCAFE_F00D;
    model_reset();
    @(negedge clk);

    // reset with pipe_en low and other inputs active
    step(0, 0, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    check("rst_pc", pc, 32'h0);
    check("rst_if_instr", if_id_instr, NOP);

    // three advances A,B,C
    step(1, 1, 0, 0, 32'h0, 32'hAAAA_0001);
    step(1, 1, 0, 0, 32'h0, 32'hBBBB_0002);
    step(1, 1, 0, 0, 32'h0, 32'hCCCC_0003);
    check("abc_pc", pc, 32'h0000_000C);
    check("abc_if", if_id_instr, 32'hCCCC_0003);
    check("abc_idex", id_ex_instr, 32'hBBBB_0002);
    check("abc_exmem", ex_mem_instr, 32'hAAAA_0001);

    // single stall, branch request ignored, then resume
    step(1, 1, 1, 1, 32'h0000_0100, 32'h1111_1111);
    check("stall_pc", pc, 32'h0000_000C);
    check("stall_if", if_id_instr, 32'hCCCC_0003);
    check("stall_idex", id_ex_instr, NOP);
    check("stall_exmem", ex_mem_instr, 32'hBBBB_0002);
    step(1, 1, 0, 0, 32'h0, 32'hDDDD_0004);

    // pipe_en low freezes everything
    step(1, 0, 0, 1, 32'h0000_0400, 32'h2222_2222);
    step(1, 0, 1, 0, 32'h0, 32'h3333_3333);

    // taken branch then advance
    step(1, 1, 0, 1, 32'h0000_0100, 32'h4444_4444);
    check("br_pc", pc, 32'h0000_0100);
    check("br_if", if_id_instr, NOP);
    step(1, 1, 0, 0, 32'h0, 32'h5555_5555);
    check("br_idex_nop", id_ex_instr, NOP);

    // pc wrap
    step(1, 1, 0, 1, 32'hFFFF_FFFC, 32'h0);
    step(1, 1, 0, 0, 32'h0, 32'h6666_6666);
    check("wrap_pc", pc, 32'h0000_0000);

    // three stalls -> halt, frozen, reset recovers
    step(1, 1, 1, 0, 32'h0, 32'h0);
    step(1, 1, 1, 0, 32'h0, 32'h0);
    check("two_stalls_no_err", {31'b0, stall_err}, 32'h0);
    step(1, 1, 1, 0, 32'h0, 32'h0);
    check("halt_err", {31'b0, stall_err}, 32'h1);
    step(1, 1, 0, 0, 32'h0, 32'h7777_7777);
    step(1, 1, 0, 1, 32'h0000_0800, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    check("halt_rst_err", {31'b0, stall_err}, 32'h0);
    check("halt_rst_pc", pc, 32'h0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 39) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, tgt, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 The block SHALL have parameter MAX_STALL, default 2, meaning the most consecutive stall cycles tolerated before fault.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning reset; synchronous and active-low.
REQ-005 The block SHALL have port pipe_en  input  1  meaning global advance enable; low freezes all state.
REQ-006 The block SHALL have port id_stall  input  1  meaning combinational stall request from the branch hazard detector.
REQ-007 The block SHALL have port branch_taken  input  1  meaning the branch in IF/ID resolves taken this cycle.
REQ-008 The block SHALL have port branch_target  input  32  meaning the redirect PC.
REQ-009 The block SHALL have port imem_instr  input  32  meaning the instruction fetched at pc.
REQ-010 The block SHALL have port pc  output  32  meaning the fetch address.
REQ-011 The block SHALL have ports if_id_instr / if_id_pc  output  32 each  meaning the IF/ID register.
REQ-012 The block SHALL have ports id_ex_instr / ex_mem_instr  output  32 each  meaning the instruction words fed back to the hazard detector.
REQ-013 The block SHALL have port stall_err  output  1  meaning sticky stall-timeout fault.

Function
REQ-014 NOP SHALL be 32'h0000_0013 (addi x0,x0,0).
REQ-015 The FSM SHALL have states RUN, STALL, HALT; the state SHALL be unchanged on any cycle with pipe_en=0.
REQ-016 With pipe_en=0, no register SHALL change.
REQ-017 With pipe_en=1, ex_mem_instr SHALL load id_ex_instr every cycle, in all states except HALT.
REQ-018 On a stall (pipe_en=1, id_stall=1, state!=HALT): pc and IF/ID SHALL hold; id_ex_instr SHALL load NOP; branch_taken SHALL be ignored.
REQ-019 On a taken branch (pipe_en=1, id_stall=0, branch_taken=1, state!=HALT): pc SHALL load branch_target; if_id_instr SHALL load NOP; if_id_pc SHALL load pc; id_ex_instr SHALL load if_id_instr.
REQ-020 On normal advance (pipe_en=1, id_stall=0, branch_taken=0, state!=HALT): pc SHALL load pc+4 (mod 2^32); if_id_instr SHALL load imem_instr; if_id_pc SHALL load pc; id_ex_instr SHALL load if_id_instr.
REQ-021 A 2-bit-minimum stall_len counter SHALL increment on each stall cycle and clear on any non-stall advance.
REQ-022 Transitions: RUN->STALL on a stall cycle; STALL->RUN on a non-stall advance; STALL->HALT on a stall cycle when stall_len==MAX_STALL.
REQ-023 In HALT, all pipeline registers SHALL hold; stall_err SHALL be 1; only reset leaves HALT.
REQ-024 pc+4 wrap from 32'hFFFF_FFFC SHALL yield 32'h0000_0000 with no flag.

Reset
REQ-025 On a rising edge with rst_n=0: pc=RESET_PC, if_id_instr=NOP, if_id_pc=0, id_ex_instr=NOP, ex_mem_instr=NOP, stall_len=0, state=RUN, stall_err=0, regardless of pipe_en or other inputs.
REQ-026 Reset asserted mid-stall or in HALT SHALL have the same result as REQ-025.

Configuration
REQ-027 Macro STALL_PERF_EN SHALL, when defined, add outputs stall_cycles[15:0] and flush_count[15:0]; both reset to 0, increment on REQ-018 and REQ-019 cycles respectively, and saturate at 16'hFFFF.
REQ-028 Without STALL_PERF_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-029 Reset then 3 cycles of imem_instr=A,B,C, id_stall=0 -> pc=0x0C, if_id_instr=C, id_ex_instr=B, ex_mem_instr=A.
REQ-030 Single stall with if_id_instr=BEQ, id_ex_instr=X -> pc and if_id_instr hold; id_ex_instr=NOP; ex_mem_instr=X; state STALL then RUN.
REQ-031 Branch: id_stall=0, branch_taken=1, branch_target=0x100 -> pc=0x100, if_id_instr=NOP; the next cycle id_ex_instr=NOP.
REQ-032 Stall with branch_taken=1 -> branch ignored; pc unchanged.
REQ-033 MAX_STALL=2: 3 consecutive stall cycles -> HALT, stall_err=1, all registers frozen; rst_n=0 for one edge -> REQ-025 values.
REQ-034 With STALL_PERF_EN: 2 stall cycles plus 1 branch -> stall_cycles=2, flush_count=1; pipe_en=0 cycles leave both counters unchanged.
